// File: rtl/load_store_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit_if
// Purpose  : Single-beat request/acknowledge data-memory port used by the
//            load/store unit.
// Ports    : mem_req   - request valid (master -> slave)
//            mem_we    - 1 = write, 0 = read (master -> slave)
//            mem_addr  - request address (master -> slave)
//            mem_wdata - write data (master -> slave)
//            mem_ack   - request completes this cycle (slave -> master)
//            mem_rdata - read data, valid with mem_ack (slave -> master)
// Revision : 1.0 - initial release
// ============================================================================
interface load_store_unit_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_ack;
   logic [DATA_W-1:0] mem_rdata;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_ack, mem_rdata
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_ack, mem_rdata
   );
endinterface
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Purpose  : Word load/store back end. Accepts one lw/sw per issue, runs a
//            single-beat transaction on the data-memory port, returns load
//            data to writeback and stalls the pipeline while busy.
// Ports    : clk, rst            - clock, asynchronous active-high reset
//            issue_valid/is_load/is_store/addr/store_data/rd - issue side
//            busy                - pipeline stall (state != IDLE)
//            mem                 - data-memory port (master modport)
//            wb_en/wb_rd/wb_data - one-cycle register writeback
//            fault               - one-cycle pulse on misaligned, illegal
//                                  (both op bits) or timed-out request
// Revision : 1.0 - initial release
// ============================================================================
module load_store_unit #(
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  wire logic               clk,
   input  wire logic               rst,
   input  wire logic               issue_valid,
   input  wire logic               is_load,
   input  wire logic               is_store,
   input  wire logic [ADDR_W-1:0]  addr,
   input  wire logic [DATA_W-1:0]  store_data,
   input  wire logic [4:0]         rd,
   output logic                    busy,
   load_store_unit_if.master       mem,
   output logic                    wb_en,
   output logic [4:0]              wb_rd,
   output logic [DATA_W-1:0]       wb_data,
   output logic                    fault
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   // Abort when the counter reaches this value: REQ then lasts exactly
   // TIMEOUT_CYCLES cycles.
   localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WB   = 2'd2
   } state_t;

   state_t            state_q,     state_d;
   logic [CNT_W-1:0]  cnt_q,       cnt_d;
   logic [4:0]        rd_q,        rd_d;
   logic              busy_q,      busy_d;
   logic              mem_req_q,   mem_req_d;
   logic              mem_we_q,    mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic              wb_en_q,     wb_en_d;
   logic [4:0]        wb_rd_q,     wb_rd_d;
   logic [DATA_W-1:0] wb_data_q,   wb_data_d;
   logic              fault_q,     fault_d;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      rd_d        = rd_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      wb_rd_d     = wb_rd_q;
      wb_data_d   = wb_data_q;
      wb_en_d     = 1'b0;
      fault_d     = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (issue_valid) begin
               if (is_load ^ is_store) begin
                  if (addr[1:0] != 2'b00) begin
                     fault_d = 1'b1;
                  end else begin
                     state_d     = S_REQ;
                     cnt_d       = '0;
                     rd_d        = rd;
                     mem_we_d    = is_store;
                     mem_addr_d  = addr;
                     // Loads present zero write data on the bus.
                     mem_wdata_d = is_store ? store_data : '0;
                  end
               end else if (is_load && is_store) begin
                  fault_d = 1'b1;
               end
            end
         end
         S_REQ: begin
            if (mem.mem_ack) begin
               if (mem_we_q) begin
                  state_d = S_IDLE;
               end else begin
                  state_d   = S_WB;
                  // x0 is hardwired to zero: the WB cycle still happens
                  // but no write is strobed.
                  wb_en_d   = (rd_q != 5'd0);
                  wb_rd_d   = rd_q;
                  wb_data_d = mem.mem_rdata;
               end
            end else if (cnt_q == c_cnt_last) begin
               state_d = S_IDLE;
               fault_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_WB: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Status outputs follow the next state so they are registered yet
      // line up with the state they describe.
      busy_d    = (state_d != S_IDLE);
      mem_req_d = (state_d == S_REQ);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         rd_q        <= '0;
         busy_q      <= 1'b0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         wb_en_q     <= 1'b0;
         wb_rd_q     <= '0;
         wb_data_q   <= '0;
         fault_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rd_q        <= rd_d;
         busy_q      <= busy_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         wb_en_q     <= wb_en_d;
         wb_rd_q     <= wb_rd_d;
         wb_data_q   <= wb_data_d;
         fault_q     <= fault_d;
      end
   end

   assign busy          = busy_q;
   assign mem.mem_req   = mem_req_q;
   assign mem.mem_we    = mem_we_q;
   assign mem.mem_addr  = mem_addr_q;
   assign mem.mem_wdata = mem_wdata_q;
   assign wb_en         = wb_en_q;
   assign wb_rd         = wb_rd_q;
   assign wb_data       = wb_data_q;
   assign fault         = fault_q;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_load_store_unit
// Purpose  : Directed self-checking bench for load_store_unit. Inputs change
//            and outputs are sampled 1 ns after each rising edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        issue_valid = 1'b0;
   logic        is_load = 1'b0;
   logic        is_store = 1'b0;
   logic [31:0] addr = '0;
   logic [31:0] store_data = '0;
   logic [4:0]  rd = '0;
   logic        busy;
   logic        wb_en;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        fault;

   int vectors = 0;
   int miscompares = 0;

   load_store_unit_if #(.ADDR_W(32), .DATA_W(32)) mif ();

   load_store_unit #(
      .ADDR_W(32),
      .DATA_W(32),
      .TIMEOUT_CYCLES(16)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .issue_valid (issue_valid),
      .is_load     (is_load),
      .is_store    (is_store),
      .addr        (addr),
      .store_data  (store_data),
      .rd          (rd),
      .busy        (busy),
      .mem         (mif),
      .wb_en       (wb_en),
      .wb_rd       (wb_rd),
      .wb_data     (wb_data),
      .fault       (fault)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic ld, input logic st, input logic [31:0] a,
                        input logic [31:0] d, input logic [4:0] r);
      issue_valid = 1'b1;
      is_load     = ld;
      is_store    = st;
      addr        = a;
      store_data  = d;
      rd          = r;
   endtask

   task automatic idle_issue();
      issue_valid = 1'b0;
      is_load     = 1'b0;
      is_store    = 1'b0;
   endtask

   initial begin
      mif.mem_ack   = 1'b0;
      mif.mem_rdata = '0;

      // ---------------- reset state ----------------
      tick();
      tick();
      check("rst_busy",    32'(busy), 32'd0);
      check("rst_req",     32'(mif.mem_req), 32'd0);
      check("rst_we",      32'(mif.mem_we), 32'd0);
      check("rst_addr",    mif.mem_addr, 32'h0);
      check("rst_wdata",   mif.mem_wdata, 32'h0);
      check("rst_wb_en",   32'(wb_en), 32'd0);
      check("rst_wb_rd",   32'(wb_rd), 32'd0);
      check("rst_wb_data", wb_data, 32'h0);
      check("rst_fault",   32'(fault), 32'd0);
      rst = 1'b0;
      tick();

      // ---------------- load 0x100 -> x5, ack in cycle 3 ----------------
      issue(1'b1, 1'b0, 32'h100, 32'hFFFF_FFFF, 5'd5);
      tick();                                   // cycle 1
      idle_issue();
      check("ld_c1_req",   32'(mif.mem_req), 32'd1);
      check("ld_c1_we",    32'(mif.mem_we), 32'd0);
      check("ld_c1_addr",  mif.mem_addr, 32'h100);
      check("ld_c1_wdata", mif.mem_wdata, 32'h0);
      check("ld_c1_busy",  32'(busy), 32'd1);
      tick();                                   // cycle 2
      check("ld_c2_req",   32'(mif.mem_req), 32'd1);
      tick();                                   // cycle 3
      check("ld_c3_req",   32'(mif.mem_req), 32'd1);
      check("ld_c3_addr",  mif.mem_addr, 32'h100);
      mif.mem_ack   = 1'b1;
      mif.mem_rdata = 32'hDEAD_BEEF;
      tick();                                   // cycle 4
      mif.mem_ack   = 1'b0;
      mif.mem_rdata = 32'h0;
      check("ld_c4_req",   32'(mif.mem_req), 32'd0);
      check("ld_c4_wb_en", 32'(wb_en), 32'd1);
      check("ld_c4_wb_rd", 32'(wb_rd), 32'd5);
      check("ld_c4_wb_dt", wb_data, 32'hDEAD_BEEF);
      check("ld_c4_busy",  32'(busy), 32'd1);
      tick();                                   // cycle 5
      check("ld_c5_wb_en", 32'(wb_en), 32'd0);
      check("ld_c5_busy",  32'(busy), 32'd0);

      // ---------------- store 0x204, zero-wait, then back-to-back load ----
      issue(1'b0, 1'b1, 32'h204, 32'h1234_5678, 5'd0);
      tick();                                   // cycle 1
      idle_issue();
      check("st_c1_req",   32'(mif.mem_req), 32'd1);
      check("st_c1_we",    32'(mif.mem_we), 32'd1);
      check("st_c1_addr",  mif.mem_addr, 32'h204);
      check("st_c1_wdata", mif.mem_wdata, 32'h1234_5678);
      check("st_c1_busy",  32'(busy), 32'd1);
      mif.mem_ack = 1'b1;
      tick();                                   // cycle 2
      mif.mem_ack = 1'b0;
      check("st_c2_busy",  32'(busy), 32'd0);
      check("st_c2_req",   32'(mif.mem_req), 32'd0);
      check("st_c2_wb_en", 32'(wb_en), 32'd0);
      issue(1'b1, 1'b0, 32'h300, 32'h0, 5'd7);
      tick();                                   // cycle 3
      idle_issue();
      check("b2b_req",     32'(mif.mem_req), 32'd1);
      check("b2b_we",      32'(mif.mem_we), 32'd0);
      check("b2b_addr",    mif.mem_addr, 32'h300);
      mif.mem_ack   = 1'b1;
      mif.mem_rdata = 32'hCAFE_F00D;
      tick();
      mif.mem_ack   = 1'b0;
      check("b2b_wb_en",   32'(wb_en), 32'd1);
      check("b2b_wb_rd",   32'(wb_rd), 32'd7);
      check("b2b_wb_dt",   wb_data, 32'hCAFE_F00D);
      tick();
      check("b2b_idle",    32'(busy), 32'd0);

      // ---------------- misaligned load 0x102 ----------------
      issue(1'b1, 1'b0, 32'h102, 32'h0, 5'd4);
      tick();                                   // cycle 1
      idle_issue();
      check("mis_fault",   32'(fault), 32'd1);
      check("mis_req",     32'(mif.mem_req), 32'd0);
      check("mis_busy",    32'(busy), 32'd0);
      tick();                                   // cycle 2
      check("mis_fault2",  32'(fault), 32'd0);
      check("mis_busy2",   32'(busy), 32'd0);

      // ---------------- both op bits: illegal ----------------
      issue(1'b1, 1'b1, 32'h200, 32'h0, 5'd4);
      tick();
      idle_issue();
      check("both_fault",  32'(fault), 32'd1);
      check("both_req",    32'(mif.mem_req), 32'd0);
      check("both_busy",   32'(busy), 32'd0);
      tick();

      // ---------------- neither op bit: no-op ----------------
      issue(1'b0, 1'b0, 32'h200, 32'h0, 5'd4);
      tick();
      idle_issue();
      check("none_fault",  32'(fault), 32'd0);
      check("none_busy",   32'(busy), 32'd0);
      check("none_req",    32'(mif.mem_req), 32'd0);

      // ---------------- timeout: no ack for 16 cycles ----------------
      issue(1'b1, 1'b0, 32'h400, 32'h0, 5'd3);
      for (int c = 1; c <= 16; c++) begin
         tick();                                // cycle c
         idle_issue();
         check($sformatf("to_c%0d_req", c),   32'(mif.mem_req), 32'd1);
         check($sformatf("to_c%0d_fault", c), 32'(fault), 32'd0);
      end
      tick();                                   // cycle 17
      check("to_c17_req",   32'(mif.mem_req), 32'd0);
      check("to_c17_fault", 32'(fault), 32'd1);
      check("to_c17_busy",  32'(busy), 32'd0);
      check("to_c17_wb_en", 32'(wb_en), 32'd0);
      tick();                                   // cycle 18: late ack
      mif.mem_ack   = 1'b1;
      mif.mem_rdata = 32'h5555_AAAA;
      check("to_c18_fault", 32'(fault), 32'd0);
      tick();                                   // cycle 19
      mif.mem_ack   = 1'b0;
      check("to_late_wb",   32'(wb_en), 32'd0);
      check("to_late_busy", 32'(busy), 32'd0);
      check("to_late_req",  32'(mif.mem_req), 32'd0);
      check("to_late_flt",  32'(fault), 32'd0);

      // ---------------- load to x0, ack in cycle 2 ----------------
      issue(1'b1, 1'b0, 32'h800, 32'h0, 5'd0);
      tick();                                   // cycle 1
      idle_issue();
      check("x0_c1_busy",  32'(busy), 32'd1);
      tick();                                   // cycle 2
      check("x0_c2_busy",  32'(busy), 32'd1);
      mif.mem_ack   = 1'b1;
      mif.mem_rdata = 32'h1111_2222;
      tick();                                   // cycle 3
      mif.mem_ack   = 1'b0;
      check("x0_c3_busy",  32'(busy), 32'd1);
      check("x0_c3_wb_en", 32'(wb_en), 32'd0);
      check("x0_c3_req",   32'(mif.mem_req), 32'd0);
      tick();                                   // cycle 4
      check("x0_c4_busy",  32'(busy), 32'd0);
      check("x0_c4_wb_en", 32'(wb_en), 32'd0);

      // ---------------- reset during a pending load ----------------
      issue(1'b1, 1'b0, 32'h500, 32'h0, 5'd9);
      tick();                                   // cycle 1
      idle_issue();
      tick();                                   // cycle 2
      check("rm_c2_req",   32'(mif.mem_req), 32'd1);
      rst = 1'b1;
      #1;                                       // no clock edge in between
      check("rm_req_now",  32'(mif.mem_req), 32'd0);
      check("rm_busy_now", 32'(busy), 32'd0);
      check("rm_addr_now", mif.mem_addr, 32'h0);
      tick();
      rst = 1'b0;
      mif.mem_ack   = 1'b1;
      mif.mem_rdata = 32'h9999_9999;
      tick();
      mif.mem_ack   = 1'b0;
      check("rm_post_wb",  32'(wb_en), 32'd0);
      check("rm_post_bsy", 32'(busy), 32'd0);
      check("rm_post_flt", 32'(fault), 32'd0);
      tick();
      check("rm_post_wb2", 32'(wb_en), 32'd0);
      issue(1'b0, 1'b1, 32'h600, 32'hA5A5_5A5A, 5'd0);
      tick();
      idle_issue();
      check("rm_next_req", 32'(mif.mem_req), 32'd1);
      check("rm_next_we",  32'(mif.mem_we), 32'd1);
      check("rm_next_adr", mif.mem_addr, 32'h600);
      check("rm_next_dat", mif.mem_wdata, 32'hA5A5_5A5A);
      mif.mem_ack = 1'b1;
      tick();
      mif.mem_ack = 1'b0;
      check("rm_next_bsy", 32'(busy), 32'd0);
      check("rm_next_r0",  32'(mif.mem_req), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/load_store_unit.md
# load_store_unit

Memory-access back end for the `lw`/`sw` control the instruction decoder produces. It accepts one word load or store per issue, performs a single-beat request/acknowledge transaction on the data-memory port, and returns load data to register writeback. While a transaction is in flight it stalls the pipeline via `busy`. Misaligned addresses and unacknowledged requests are reported on `fault`.

## Interface
Parameters:
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data word width
- `TIMEOUT_CYCLES`, 16, maximum cycles in REQ without `mem_ack` before abort (≥1)

Ports:
- `clk`  in  1  single clock, all state updates on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `issue_valid`  in  1  pipeline presents a memory instruction
- `is_load`  in  1  decoded `lw`
- `is_store`  in  1  decoded `sw`
- `addr`  in  ADDR_W  effective address
- `store_data`  in  DATA_W  `rs2` value for stores
- `rd`  in  5  load destination register
- `busy`  out  1  stall; high whenever state ≠ IDLE
- `mem_req`  out  1  request valid
- `mem_we`  out  1  1 = write, 0 = read
- `mem_addr`  out  ADDR_W  request address
- `mem_wdata`  out  DATA_W  write data
- `mem_ack`  in  1  memory completes request this cycle
- `mem_rdata`  in  DATA_W  read data, valid when `mem_ack` is high
- `wb_en`  out  1  one-cycle writeback strobe
- `wb_rd`  out  5  writeback register
- `wb_data`  out  DATA_W  writeback value
- `fault`  out  1  one-cycle error pulse

## Operation
- States: IDLE, REQ, WB. All outputs registered; `busy` = (state ≠ IDLE).
- Accept: in IDLE with `issue_valid` high and exactly one of `is_load`/`is_store` high. Latch `addr`, `store_data`, `rd`, and op type.
- IDLE, accepted, `addr[1:0]` ≠ 0 → stay IDLE, no request, `fault` pulses next cycle.
- IDLE, `issue_valid` with both or neither op bit → no request; both high also pulses `fault`; neither is a no-op.
- IDLE, valid aligned accept → REQ, and clear timeout counter.
- REQ: `mem_req`=1; `mem_we`/`mem_addr`/`mem_wdata` held stable; `mem_wdata` = 0 for loads.
- REQ, `mem_ack`=1 → load: capture `mem_rdata`, go to WB; store: go to IDLE.
- REQ, no ack: increment counter; on reaching `TIMEOUT_CYCLES` drop `mem_req`, pulse `fault`, go to IDLE, no writeback.
- WB: `wb_en`=1 for one cycle with `wb_rd`/`wb_data`, then IDLE. If `rd`=0, `wb_en` stays 0, but the WB cycle still occurs.
- `mem_ack` outside REQ is ignored. `issue_valid` while `busy` is ignored; the pipeline is required to hold it.
- Reset values: state IDLE; `busy`, `mem_req`, `mem_we`, `wb_en`, `fault` = 0; `mem_addr`, `mem_wdata`, `wb_rd`, `wb_data` = 0; counter = 0.
- Reset mid-transaction: immediate abort; `mem_req` drops asynchronously; no writeback or fault.

## Timing
- Accept at edge of cycle 0 → `mem_req` high in cycle 1.
- Ack sampled high in cycle k (k≥1) → `mem_req` low in cycle k+1.
- Load: `wb_en` high in cycle k+1; `busy` high cycles 1..k+1; next accept possible at cycle k+2.
- Store: `busy` high cycles 1..k; next accept possible at cycle k+1.
- Zero-wait memory (ack in cycle 1): load occupies 2 busy cycles, store occupies 1.
- Timeout: `mem_req` high for exactly `TIMEOUT_CYCLES` cycles; `fault` pulses in the following cycle, with `busy` low in that cycle.
- Misaligned or illegal issue: `fault` pulses in cycle 1; `busy` never rises.

## Test plan
- Load, `addr`=0x100, `rd`=5, ack in cycle 3 with `mem_rdata`=0xDEADBEEF → `mem_req` high cycles 1-3 with `mem_we`=0; `wb_en` in cycle 4 with `wb_rd`=5, `wb_data`=0xDEADBEEF.
- Store, `addr`=0x204, `store_data`=0x12345678, ack in cycle 1 → one `mem_req` cycle with `mem_we`=1 and correct addr/data; `busy` low in cycle 2; back-to-back load accepted in cycle 2.
- Misaligned load at `addr`=0x102 → no `mem_req`; `fault` pulse in cycle 1; `busy` stays 0.
- No ack with `TIMEOUT_CYCLES`=16 → `mem_req` high cycles 1-16; `fault` in cycle 17; no `wb_en`; a late `mem_ack` in cycle 18 is ignored.
- Load with `rd`=0, ack in cycle 2 → `busy` high cycles 1-3; `wb_en` never asserts.
- `rst` asserted in cycle 2 of a pending load → `mem_req`, `busy`, and all outputs go to 0 immediately; no `wb_en` after release; the next issue is handled normally.
